// File: rtl/page_recycler.sv
// Walks released page chains through the next-page table and pushes each page to the free list.
// Optional chain-length guard enabled by defining PAGE_GUARD_EN.
module page_recycler #(
    parameter int ADDR_W    = 11,
    parameter int NUM_PAGES = 2048,
    parameter int REQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rel_valid,
    output logic              rel_ready,
    input  logic [ADDR_W-1:0] rel_head,
    input  logic [ADDR_W-1:0] rel_tail,
    output logic              nxt_rd_en,
    output logic [ADDR_W-1:0] nxt_rd_addr,
    input  logic [ADDR_W-1:0] nxt_rd_data,
    output logic              push_tail,
    output logic [ADDR_W-1:0] tail_addr,
    output logic              busy,
    output logic              chain_err
);

    localparam int PW = $clog2(REQ_DEPTH);

    typedef enum logic {IDLE, WALK} state_t;

    if ((1 << ADDR_W) < NUM_PAGES) begin : g_bad_cfg
        $error("NUM_PAGES exceeds the page address space");
    end

    state_t            state, next_state;
    logic [ADDR_W-1:0] q_head [REQ_DEPTH];
    logic [ADDR_W-1:0] q_tail [REQ_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              full, empty, acc, pop;
    logic [ADDR_W-1:0] head_r, tail_r, p;
    logic              first, abort;

    assign full      = (count == (PW+1)'(REQ_DEPTH));
    assign empty     = (count == '0);
    assign rel_ready = !full;
    assign acc       = rel_valid && rel_ready;
    assign busy      = (state != IDLE) || !empty;
    assign p         = first ? head_r : nxt_rd_data;

`ifdef PAGE_GUARD_EN
    localparam int CW = $clog2(NUM_PAGES) + 1;
    logic [CW-1:0] cnt;

    assign abort = (cnt == CW'(NUM_PAGES));

    // Count pushes of the current chain; cleared when a chain is popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= '0;
        end else if (push_tail) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // Release request FIFO of {head, tail}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < REQ_DEPTH; i++) begin
                q_head[i] <= '0;
                q_tail[i] <= '0;
            end
        end else begin
            if (acc) begin
                q_head[wr_ptr] <= rel_head;
                q_tail[wr_ptr] <= rel_tail;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State and current-chain registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            head_r <= '0;
            tail_r <= '0;
            first  <= 1'b0;
        end else begin
            state <= next_state;
            if (pop) begin
                head_r <= q_head[rd_ptr];
                tail_r <= q_tail[rd_ptr];
                first  <= 1'b1;
            end else if (state == WALK) begin
                first <= 1'b0;
            end
        end
    end

    // Next-state and walk outputs
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        push_tail   = 1'b0;
        tail_addr   = '0;
        nxt_rd_en   = 1'b0;
        nxt_rd_addr = '0;
        chain_err   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = WALK;
                end
            end
            WALK: begin
                if (abort) begin
                    chain_err  = 1'b1;
                    next_state = IDLE;
                end else begin
                    push_tail = 1'b1;
                    tail_addr = p;
                    if (p == tail_r) begin
                        next_state = IDLE;
                    end else begin
                        nxt_rd_en   = 1'b1;
                        nxt_rd_addr = p;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
